// File: rtl/prefix_post_pipe_64b.sv
// Kogge-Stone prefix tree back end for the 64-bit adder: consumes per-bit
// propagate/generate (bit 0 = carry-in) and produces sum and carry-out through an elastic pipeline.
module prefix_post_pipe_64b #(
  parameter int LEVELS_PER_STAGE = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [64:0] prop_i,
  input  logic [64:0] gen_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [63:0] sum_o,
  output logic        carry_o
);

  localparam int NUM_STAGES = (7 + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  function automatic logic [64:0] level_g(input logic [64:0] g, input logic [64:0] p,
                                          input int k);
    return g | (p & (g << (1 << k)));
  endfunction

  // Low 2^k bits have no partner at this level and keep their propagate unchanged.
  function automatic logic [64:0] level_p(input logic [64:0] p, input int k);
    logic [64:0] low;
    low = (65'd1 << (1 << k)) - 65'd1;
    return p & ((p << (1 << k)) | low);
  endfunction

  logic [64:0] g_in  [NUM_STAGES];
  logic [64:0] p_in  [NUM_STAGES];
  logic [63:0] po_in [NUM_STAGES];

  logic [NUM_STAGES-1:0] v_q, v_d, ld;
  logic [NUM_STAGES:0]   v_up;
  logic [63:0]           sum_q, sum_d;
  logic                  carry_q, carry_d;

  assign g_in[0]  = gen_i;
  assign p_in[0]  = prop_i;
  assign po_in[0] = prop_i[64:1];

  // A stage may load if it or any stage below it is empty, or the sink takes the result.
  always_comb begin
    logic acc;
    acc = ready_i;
    ld  = '0;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      acc   = acc | ~v_q[s];
      ld[s] = acc;
    end
  end

  assign v_up = {v_q, valid_i};

  always_comb begin
    v_d = v_q;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (ld[s]) v_d[s] = v_up[s];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) v_q <= '0;
    else       v_q <= v_d;
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int LO = s * LEVELS_PER_STAGE;
    localparam int HI = ((s + 1) * LEVELS_PER_STAGE > 7) ? 7 : (s + 1) * LEVELS_PER_STAGE;

    logic [64:0] g_c, p_c;

    always_comb begin
      g_c = g_in[s];
      p_c = p_in[s];
      for (int k = LO; k < HI; k++) begin
        g_c = level_g(g_c, p_c, k);
        p_c = level_p(p_c, k);
      end
    end

    if (s < NUM_STAGES - 1) begin : g_mid
      logic [64:0] g_q, p_q;
      logic [63:0] po_q;

      // ---- stage s register boundary ----
      always_ff @(posedge clk_i) begin
        if (ld[s]) begin
          g_q  <= g_c;
          p_q  <= p_c;
          po_q <= po_in[s];
        end
      end

      assign g_in[s+1]  = g_q;
      assign p_in[s+1]  = p_q;
      assign po_in[s+1] = po_q;
    end else begin : g_last
      always_comb begin
        sum_d   = po_in[s] ^ g_c[63:0];
        carry_d = g_c[64];
      end
    end
  end

  // ---- output register boundary ----
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (ld[NUM_STAGES-1]) begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign ready_o = ld[0];
  assign valid_o = v_q[NUM_STAGES-1];
  assign sum_o   = sum_q;
  assign carry_o = carry_q;

endmodule

// File: tb/tb_prefix_post_pipe_64b.sv
// Bench for prefix_post_pipe_64b: directed sums, back-to-back streams at three
// stage splits, random back-pressure, and asynchronous reset mid-stream.
module tb_prefix_post_pipe_64b;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [64:0] prop_i = '0;
  logic [64:0] gen_i = '0;
  logic        ready_i = 1'b0;
  logic        aux_rdy = 1'b1;

  logic        ready_o, valid_o, carry_o;
  logic [63:0] sum_o;
  logic        rdy1_o, vld1_o, car1_o;
  logic [63:0] sum1_o;
  logic        rdy7_o, vld7_o, car7_o;
  logic [63:0] sum7_o;

  prefix_post_pipe_64b #(.LEVELS_PER_STAGE(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(valid_o), .ready_i(ready_i),
    .sum_o(sum_o), .carry_o(carry_o));

  prefix_post_pipe_64b #(.LEVELS_PER_STAGE(1)) dut_l1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy1_o),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(vld1_o), .ready_i(aux_rdy),
    .sum_o(sum1_o), .carry_o(car1_o));

  prefix_post_pipe_64b #(.LEVELS_PER_STAGE(7)) dut_l7 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(rdy7_o),
    .prop_i(prop_i), .gen_i(gen_i), .valid_o(vld7_o), .ready_i(aux_rdy),
    .sum_o(sum7_o), .carry_o(car7_o));

  always #5 clk = ~clk;

  logic        vo_a  [3];
  logic        rdy_a [3];
  logic [64:0] ro_a  [3];
  always_comb begin
    vo_a[0] = valid_o; rdy_a[0] = ready_o; ro_a[0] = {carry_o, sum_o};
    vo_a[1] = vld1_o;  rdy_a[1] = rdy1_o;  ro_a[1] = {car1_o, sum1_o};
    vo_a[2] = vld7_o;  rdy_a[2] = rdy7_o;  ro_a[2] = {car7_o, sum7_o};
  end

  int n_pass = 0;
  int n_total = 0;
  logic [64:0] q_main[$];
  localparam int NSTREAM = 1000;
  logic [64:0] exp_arr [NSTREAM];

  function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin);
    return {1'b0, a} + {1'b0, b} + {64'd0, cin};
  endfunction

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0: return '1;
      1: return '0;
      2: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic drive(input logic vld, input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic rdy);
    @(negedge clk);
    valid_i = vld;
    prop_i  = {a ^ b, 1'b0};
    gen_i   = {a & b, cin};
    ready_i = rdy;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_i = 1'b1;
    valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    q_main.delete();
  endtask

  task automatic send_single(input logic [63:0] a, input logic [63:0] b, input logic cin,
                             output int lat, output logic [64:0] res);
    lat = -1;
    res = '0;
    drive(1'b1, a, b, cin, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (valid_o === 1'b1) begin
        lat = c;
        res = {carry_o, sum_o};
        break;
      end
    end
  endtask

  task automatic test_reset();
    ready_i = 1'b1;
    @(negedge clk);
    #1;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o);
    else n_pass++;
    n_total++;
    if ({carry_o, sum_o} !== 65'd0) $display("FAIL reset_data: got %h want 0", {carry_o, sum_o});
    else n_pass++;
    rst_i = 1'b0;
    #1;
    n_total++;
    if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [63:0] av [4];
    logic [63:0] bv [4];
    logic        cv [4];
    logic [64:0] ev [4];
    int          lat;
    logic [64:0] res;
    av[0] = 64'hFFFF_FFFF_FFFF_FFFF; bv[0] = 64'h1; cv[0] = 1'b0; ev[0] = 65'h1_0000_0000_0000_0000;
    av[1] = 64'h0; bv[1] = 64'h0; cv[1] = 1'b1; ev[1] = 65'h0_0000_0000_0000_0001;
    av[2] = 64'h8000_0000_0000_0000; bv[2] = 64'h8000_0000_0000_0000; cv[2] = 1'b0;
    ev[2] = 65'h1_0000_0000_0000_0000;
    av[3] = {$urandom, $urandom}; bv[3] = {$urandom, $urandom}; cv[3] = 1'b1;
    ev[3] = model(av[3], bv[3], cv[3]);
    for (int i = 0; i < 4; i++) begin
      send_single(av[i], bv[i], cv[i], lat, res);
      n_total++;
      if (lat != 4) $display("FAIL directed_latency[%0d]: got %0d want 4", i, lat);
      else n_pass++;
      n_total++;
      if (res !== ev[i]) $display("FAIL directed_sum[%0d]: got %h want %h", i, res, ev[i]);
      else n_pass++;
    end
  endtask

  // Plan items 3 and 6: all three stage splits see the same stream with ready held high.
  task automatic test_back_to_back();
    int          rd [3];
    int          lat_a [3];
    int          wr;
    logic [63:0] a, b;
    logic        c;
    logic        exp_v;
    lat_a[0] = 4; lat_a[1] = 7; lat_a[2] = 1;
    rd[0] = 0; rd[1] = 0; rd[2] = 0;
    wr = 0;
    pulse_reset();
    for (int idx = 0; idx < NSTREAM + 10; idx++) begin
      a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
      drive(idx < NSTREAM, a, b, c, 1'b1);
      for (int d = 0; d < 3; d++) begin
        exp_v = (idx >= lat_a[d]) && (idx < NSTREAM + lat_a[d]);
        n_total++;
        if (vo_a[d] !== exp_v)
          $display("FAIL b2b_valid[dut%0d,cyc%0d]: got %b want %b", d, idx, vo_a[d], exp_v);
        else n_pass++;
        if (vo_a[d] === 1'b1) begin
          n_total++;
          if (rd[d] >= wr) $display("FAIL b2b_extra[dut%0d]: got result %h want none", d, ro_a[d]);
          else if (ro_a[d] !== exp_arr[rd[d]])
            $display("FAIL b2b_sum[dut%0d,#%0d]: got %h want %h", d, rd[d], ro_a[d], exp_arr[rd[d]]);
          else n_pass++;
          rd[d]++;
        end
        if (valid_i && rdy_a[d] !== 1'b1) begin
          n_total++;
          $display("FAIL b2b_ready[dut%0d]: got %b want 1", d, rdy_a[d]);
        end
      end
      if (valid_i) begin
        exp_arr[wr] = model(a, b, c);
        wr++;
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (rd[d] != NSTREAM) $display("FAIL b2b_count[dut%0d]: got %0d want %0d", d, rd[d], NSTREAM);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b;
    logic        c, rdy, prev_stall, exp_rdy;
    logic [64:0] prev_res, e;
    pulse_reset();
    a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
    prev_stall = 1'b0;
    prev_res = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rdy = 1'($urandom_range(0, 1));
      drive(1'b1, a, b, c, rdy);
      exp_rdy = rdy || (q_main.size() < 4);
      n_total++;
      if (ready_o !== exp_rdy) $display("FAIL bp_ready[cyc%0d]: got %b want %b", cyc, ready_o, exp_rdy);
      else n_pass++;
      if (prev_stall) begin
        n_total++;
        if (valid_o !== 1'b1 || {carry_o, sum_o} !== prev_res)
          $display("FAIL bp_stall_hold[cyc%0d]: got %b/%h want 1/%h", cyc, valid_o, {carry_o, sum_o}, prev_res);
        else n_pass++;
      end
      if (valid_o === 1'b1 && rdy) begin
        n_total++;
        if (q_main.size() == 0) $display("FAIL bp_dup: got result %h want none", {carry_o, sum_o});
        else begin
          e = q_main.pop_front();
          if ({carry_o, sum_o} !== e) $display("FAIL bp_sum[cyc%0d]: got %h want %h", cyc, {carry_o, sum_o}, e);
          else n_pass++;
        end
      end
      if (ready_o === 1'b1) begin
        q_main.push_back(model(a, b, c));
        a = rand_op(); b = rand_op(); c = 1'($urandom_range(0, 1));
      end
      prev_stall = (valid_o === 1'b1) && !rdy;
      prev_res = {carry_o, sum_o};
    end
    for (int cyc = 0; cyc < 20 && q_main.size() > 0; cyc++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      if (valid_o === 1'b1) begin
        e = q_main.pop_front();
        n_total++;
        if ({carry_o, sum_o} !== e) $display("FAIL bp_drain_sum: got %h want %h", {carry_o, sum_o}, e);
        else n_pass++;
      end
    end
    n_total++;
    if (q_main.size() != 0) $display("FAIL bp_lost: got %0d outstanding want 0", q_main.size());
    else n_pass++;
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL bp_extra_out: got valid %b want 0", valid_o);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int          lat;
    logic [64:0] res;
    logic [63:0] a, b;
    pulse_reset();
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    drive(1'b1, rand_op(), rand_op(), 1'b0, 1'b0);
    drive(1'b1, rand_op(), rand_op(), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_total++;
    if ({valid_o, carry_o, sum_o} !== {1'b1, 65'h1_FFFF_FFFF_FFFF_FFFF})
      $display("FAIL rst_pre_state: got %b/%h want 1/1ffffffffffffffff", valid_o, {carry_o, sum_o});
    else n_pass++;
    rst_i = 1'b1;
    #1;
    n_total++;
    if (valid_o !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", valid_o);
    else n_pass++;
    n_total++;
    if ({carry_o, sum_o} !== 65'd0) $display("FAIL rst_async_data: got %h want 0", {carry_o, sum_o});
    else n_pass++;
    @(negedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    n_total++;
    if ({ready_o, valid_o} !== 2'b10) $display("FAIL rst_release: got ready/valid %b want 10", {ready_o, valid_o});
    else n_pass++;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    send_single(a, b, 1'b0, lat, res);
    n_total++;
    if (lat != 4) $display("FAIL rst_new_latency: got %0d want 4", lat);
    else n_pass++;
    n_total++;
    if (res !== model(a, b, 1'b0)) $display("FAIL rst_new_sum: got %h want %h", res, model(a, b, 1'b0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
